// File: rtl/fifo_push_arbiter.sv
// Round-robin push arbiter in front of a single FIFO write port.
// A winner keeps the port for up to max_burst consecutive words.
// A full FIFO pauses the burst without breaking it.
module fifo_push_arbiter #(
  parameter int unsigned n_req     = 4,
  parameter int unsigned width     = 64,
  parameter int unsigned max_burst = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [n_req-1:0]         req,
  input  logic [n_req*width-1:0]   req_data,
  input  logic                     fifo_full,
  output logic [n_req-1:0]         gnt,
  output logic                     fifo_push,
  output logic [width-1:0]         fifo_write_data
);

  localparam int unsigned IdxW = (n_req > 1) ? $clog2(n_req) : 1;
  localparam int unsigned CntW = $clog2(max_burst + 1);
  localparam logic [CntW-1:0] CntMax  = CntW'(max_burst);
  localparam logic [IdxW-1:0] LastRst = IdxW'(n_req - 1);

  typedef enum logic {StIdle, StBurst} state_e;

  state_e          state_q, state_d;
  logic [IdxW-1:0] owner_q, owner_d;
  logic [IdxW-1:0] last_q, last_d;
  logic [CntW-1:0] cnt_q, cnt_d;

  logic            pick_valid;
  logic [IdxW-1:0] pick_idx;
  logic [IdxW-1:0] scan_idx;
  logic            grant_en;
  logic [IdxW-1:0] grant_idx;

  // Round-robin pick: scan downward so the nearest index after last_q wins.
  always_comb begin
    pick_valid = 1'b0;
    pick_idx   = '0;
    scan_idx   = '0;
    for (int k = int'(n_req); k >= 1; k--) begin
      scan_idx = IdxW'((int'(last_q) + k) % int'(n_req));
      if (req[scan_idx]) begin
        pick_valid = 1'b1;
        pick_idx   = scan_idx;
      end
    end
  end

  // Grant decision and next-state; a full FIFO freezes all state.
  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    cnt_d     = cnt_q;
    last_d    = last_q;
    grant_en  = 1'b0;
    grant_idx = owner_q;
    if (!fifo_full) begin
      if (state_q == StBurst && req[owner_q]) begin
        grant_en  = 1'b1;
        grant_idx = owner_q;
        cnt_d     = cnt_q + 1'b1;
        if (cnt_d == CntMax) state_d = StIdle;
      end else if (pick_valid) begin
        grant_en  = 1'b1;
        grant_idx = pick_idx;
        owner_d   = pick_idx;
        cnt_d     = CntW'(1);
        state_d   = (max_burst > 1) ? StBurst : StIdle;
      end else begin
        state_d = StIdle;
      end
      if (grant_en) last_d = grant_idx;
    end
  end

  // Outputs are forced quiet while reset is asserted, independent of req.
  always_comb begin
    gnt             = '0;
    fifo_write_data = '0;
    if (rst_n && grant_en) begin
      gnt[grant_idx]  = 1'b1;
      fifo_write_data = req_data[int'(grant_idx)*int'(width) +: width];
    end
    fifo_push = |gnt;
  end

  // State registers; reset points last at n_req-1 so the first pick is index 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      owner_q <= '0;
      cnt_q   <= '0;
      last_q  <= LastRst;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      cnt_q   <= cnt_d;
      last_q  <= last_d;
    end
  end

endmodule

// File: tb/tb_fifo_push_arbiter.sv
// Bench for fifo_push_arbiter: directed scenarios with literal expectations,
// then randomized traffic checked every cycle against a behavioural model.
module tb_fifo_push_arbiter;

  localparam int N  = 4;
  localparam int W  = 64;
  localparam int MB = 4;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [N-1:0]     req;
  logic [N*W-1:0]   req_data;
  logic             fifo_full;
  logic [N-1:0]     gnt;
  logic             fifo_push;
  logic [W-1:0]     fifo_write_data;

  int errors = 0;
  int checks = 0;

  // Behavioural model state
  bit m_burst;
  int m_owner, m_cnt, m_last;

  int e30[7] = '{1, 1, 0, 0, 1, 1, 2};
  int f30[7] = '{0, 0, 1, 1, 0, 0, 0};
  int r31[7] = '{3, 3, 2, 3, 3, 3, 3};
  int e31[7] = '{1, 1, 2, 2, 2, 2, 1};

  fifo_push_arbiter #(.n_req(N), .width(W), .max_burst(MB)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .req             (req),
    .req_data        (req_data),
    .fifo_full       (fifo_full),
    .gnt             (gnt),
    .fifo_push       (fifo_push),
    .fifo_write_data (fifo_write_data)
  );

  always #5 clk = ~clk;

  // Index the model says is granted now, or -1 for no grant.
  function automatic int exp_grant();
    if (fifo_full) return -1;
    if (m_burst && req[m_owner]) return m_owner;
    for (int k = 1; k <= N; k++) begin
      if (req[(m_last + k) % N]) return (m_last + k) % N;
    end
    return -1;
  endfunction

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // Model advances on each accepted clock edge.
  always @(posedge clk or negedge rst_n) begin
    int g;
    if (!rst_n) begin
      m_burst <= 1'b0;
      m_owner <= 0;
      m_cnt   <= 0;
      m_last  <= N - 1;
    end else if (!fifo_full) begin
      g = exp_grant();
      if (g < 0) begin
        m_burst <= 1'b0;
      end else begin
        m_last <= g;
        if (m_burst && g == m_owner) begin
          m_cnt <= m_cnt + 1;
          if (m_cnt + 1 == MB) m_burst <= 1'b0;
        end else begin
          m_owner <= g;
          m_cnt   <= 1;
          m_burst <= (MB > 1);
        end
      end
    end
  end

  // Every-cycle comparison against the model, mid-cycle.
  always @(negedge clk) begin
    int g;
    logic [N-1:0] eg;
    logic [W-1:0] ed;
    eg = '0;
    ed = '0;
    if (rst_n) begin
      g = exp_grant();
      if (g >= 0) begin
        eg[g] = 1'b1;
        ed    = req_data[g*W +: W];
      end
    end
    chk("model_gnt", W'(gnt), W'(eg));
    chk("model_push", W'(fifo_push), W'(|eg));
    chk("model_data", fifo_write_data, ed);
  end

  task automatic drive(input logic [N-1:0] r, input logic f);
    @(posedge clk);
    #1;
    req       = r;
    fifo_full = f;
  endtask

  // Literal expectation, sampled 3 time units after the active edge.
  task automatic lit(input string name, input logic [N-1:0] eg, input logic [W-1:0] ed);
    #2;
    chk({name, "_gnt"}, W'(gnt), W'(eg));
    chk({name, "_push"}, W'(fifo_push), W'(|eg));
    chk({name, "_data"}, fifo_write_data, ed);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    req   = '1;
    #2;
    chk("in_reset_gnt", W'(gnt), '0);
    chk("in_reset_data", fifo_write_data, '0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    req   = '0;
  endtask

  initial begin
    rst_n     = 1'b0;
    req       = '1;
    fifo_full = 1'b0;
    for (int j = 0; j < N; j++) req_data[j*W +: W] = W'(64'hA0 + j);

    // Single requester held: granted every cycle, bursts back to back.
    do_reset();
    for (int i = 0; i < 8; i++) begin
      drive(4'b0001, 1'b0);
      lit("single", 4'b0001, 64'hA0);
    end

    // All requesting: four grants each in round-robin order.
    do_reset();
    for (int i = 0; i < 20; i++) begin
      drive(4'b1111, 1'b0);
      lit("rr", N'(1 << ((i / 4) % 4)), W'(64'hA0 + (i / 4) % 4));
    end

    // Full FIFO pauses the burst of index 0 after its second word.
    do_reset();
    for (int i = 0; i < 7; i++) begin
      drive(4'b1111, f30[i][0]);
      lit("full_pause", N'(e30[i]), (e30[i] == 0) ? '0 : W'(64'hA0 + e30[i] / 2));
    end

    // Owner drops req mid-burst: same-cycle handover to index 1.
    do_reset();
    for (int i = 0; i < 7; i++) begin
      drive(N'(r31[i]), 1'b0);
      lit("handover", N'(e31[i]), W'(64'hA0 + e31[i] / 2));
    end

    // Reset pulse in the middle of index 2's burst.
    do_reset();
    for (int i = 0; i < 10; i++) drive(4'b1111, 1'b0);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    lit("mid_reset", 4'b0000, '0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    lit("post_reset", 4'b0001, 64'hA0);

    // Each requester alone selects its own data slice.
    for (int r = 0; r < N; r++) begin
      drive(N'(1 << r), 1'b0);
      lit("slice", N'(1 << r), W'(64'hA0 + r));
    end
    drive(4'b0000, 1'b0);
    lit("idle", 4'b0000, '0);

    // Randomized traffic, occasional one-cycle resets.
    for (int i = 0; i < 4000; i++) begin
      @(posedge clk);
      #1;
      rst_n     = ($urandom_range(0, 299) != 0);
      req       = N'($urandom);
      fifo_full = ($urandom_range(0, 3) == 0);
      for (int j = 0; j < N * W / 32; j++) req_data[j*32 +: 32] = $urandom;
    end

    @(posedge clk);
    #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fifo_push_arbiter.md
FIFO_PUSH_ARBITER -- requirements
Module: fifo_push_arbiter

Interface
REQ-001 The block SHALL have parameter n_req, default 4, meaning the number of requesters (2..16).
REQ-002 The block SHALL have parameter width, default 64, meaning the data width per requester and of the FIFO write port.
REQ-003 The block SHALL have parameter max_burst, default 4, meaning the maximum consecutive grants to one owner (1..16).
REQ-004 The block SHALL have one clock; reset SHALL be asynchronous and active-low, and the ports SHALL be named clk and rst_n.
REQ-005 clk  input  1  rising-edge clock.
REQ-006 rst_n  input  1  asynchronous active-low reset.
REQ-007 req  input  n_req  per-requester push request; bit i belongs to requester i.
REQ-008 req_data  input  n_req*width  requester i data in bits [i*width +: width].
REQ-009 fifo_full  input  1  full flag of the downstream power-of-two FIFO.
REQ-010 gnt  output  n_req  one-hot accept; a word is taken from requester i in any cycle where gnt[i]=1.
REQ-011 fifo_push  output  1  push strobe to the FIFO.
REQ-012 fifo_write_data  output  width  data to the FIFO write port.

Function
REQ-013 gnt, fifo_push and fifo_write_data SHALL be combinational from the current inputs and registered state, with zero-cycle latency from req to gnt.
REQ-014 fifo_push SHALL equal the OR of gnt, and gnt SHALL be zero or one-hot.
REQ-015 fifo_write_data SHALL equal the req_data slice of the granted index, and SHALL be all zeros when nothing is granted.
REQ-016 No grant SHALL occur in any cycle where fifo_full=1, and the registered state SHALL hold unchanged in such a cycle (the burst pauses but is not broken).
REQ-017 The registered state SHALL be: state {IDLE, BURST}, owner ($clog2(n_req) bits), cnt ($clog2(max_burst+1) bits), and last (index of the last grant).
REQ-018 Round-robin pick: the first i with req[i]=1, scanning last+1, last+2, ... modulo n_req.
REQ-019 IDLE with fifo_full=0 and any req: the block SHALL grant the pick and set owner=last=pick and cnt=1, then go to BURST if 1<max_burst, else stay in IDLE.
REQ-020 BURST with fifo_full=0 and req[owner]=1: the block SHALL grant owner and increment cnt, and when the new cnt equals max_burst it SHALL return to IDLE.
REQ-021 BURST with fifo_full=0, req[owner]=0 and another req present: the block SHALL perform the round-robin pick in the same cycle and behave as in IDLE (REQ-019).
REQ-022 BURST with fifo_full=0 and req=0: the block SHALL go to IDLE with no grant.
REQ-023 Index arithmetic SHALL wrap modulo n_req, including for n_req values that are not powers of two.
REQ-024 A requester dropping req while it has no grant SHALL have no effect on the state.

Reset
REQ-025 rst_n=0 SHALL immediately and asynchronously force state=IDLE, owner=0, cnt=0 and last=n_req-1, so that the first pick after reset starts at index 0.
REQ-026 While rst_n=0, gnt, fifo_push and fifo_write_data SHALL all be 0, regardless of req.
REQ-027 Reset asserted mid-burst SHALL discard the burst, with no residual count after release.

Verification (n_req=4, max_burst=4, width=64)
REQ-028 Reset, then req=4'b0001 held and fifo_full=0 -> gnt=0001 and fifo_push=1 every cycle; state cycles BURST x3 then IDLE; fifo_write_data=req_data[63:0].
REQ-029 req=4'b1111 held -> gnt sequence 0001 x4, 0010 x4, 0100 x4, 1000 x4, then 0001 again.
REQ-030 req=4'b1111 with fifo_full=1 for 2 cycles after the 2nd grant to index 0 -> gnt=0 and fifo_push=0 for those 2 cycles, then 2 more grants to index 0, then index 1.
REQ-031 req=4'b0011, with req[0] deasserted after 2 grants to index 0 -> gnt=0010 in that same cycle, and a new burst for index 1 with cnt=1.
REQ-032 rst_n pulsed low mid-burst of index 2 with req=4'b1111 -> outputs 0 during reset; the first grant after release is 0001.
REQ-033 req_data slices set to distinct values 0xA0..0xA3 with a single requester active in turn -> fifo_write_data matches the granted slice exactly and is 0 when gnt=0.
